ins_fetch_seq: RTL
==================

Name: ins_fetch_seq

Overview:
Fetch sequencer for the single-cycle CPU's byte-wide, big-endian instruction memory. Each cycle it issues one byte read and assembles four bytes into a 32-bit instruction. It presents the word to decode over a valid/ready handshake and owns the PC, advancing it by 4 per accepted instruction or loading a redirect target from branch/jump logic. It replaces direct PC-to-memory indexing whenever the memory has a registered read port.

Parameters:
ADDR_W, 8, instruction-memory byte-address width (256 bytes)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_rd  output  1  byte read strobe to instruction memory
mem_addr  output  ADDR_W  byte address = pc[ADDR_W-1:0] + k
mem_rdata  input  8  read byte, valid exactly one cycle after mem_rd
ins_valid  output  1  ins/ins_pc hold a complete instruction
ins_ready  input  1  decode accepts instruction
ins  output  32  assembled instruction, byte k at bits [31-8k:24-8k]
ins_pc  output  32  address of ins
redirect  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  32  new PC
align_err  output  1  redirect target not word-aligned

Behaviour:
- Reset: state FETCH with k=0. pc=RESET_PC, ins=0, ins_pc=0, ins_valid=0, mem_rd=0, mem_addr=0, align_err=0.
- States: FETCH (k=0..4), VALID, HALT.
- FETCH, k=0..3: mem_rd=1, mem_addr=pc[ADDR_W-1:0]+k (mod 2^ADDR_W, wraps). k++ each cycle.
- FETCH, k=1..4: capture mem_rdata into byte k-1 of the shift register.
- FETCH, k=4: mem_rd=0. Next cycle: state VALID, ins_valid=1, ins_pc=pc.
- Latency: ins_valid rises 5 cycles after entering FETCH. Steady throughput is 1 instruction per 6 cycles with ins_ready tied high.
- VALID: ins/ins_pc held stable while ins_ready=0.
- VALID, ins_ready=1: transfer occurs, pc=pc+4 (32-bit, wraps at 2^32), state FETCH with k=0, ins_valid=0 next cycle.
- Redirect priority: highest, evaluated in every state.
  - redirect=1 with redirect_pc[1:0]==0: pc=redirect_pc, partial bytes discarded, state FETCH with k=0, ins_valid=0 next cycle, align_err=0.
  - redirect in VALID together with ins_ready=1: the transfer counts, but pc takes redirect_pc, not pc+4.
  - redirect during FETCH: the in-flight byte returned next cycle is ignored.
  - redirect=1 with redirect_pc[1:0]!=0: align_err=1, state HALT, ins_valid=0, mem_rd=0, pc unchanged.
- HALT: exited only by an aligned redirect, which clears align_err.
- Reset asserted mid-fetch or in VALID: immediate return to reset values; no partial instruction is ever presented.
- mem_addr is a don't-care when mem_rd=0 but is driven stable (last value) to avoid toggling.

Optional Feature:
FETCH_STATS_EN defined:
- adds outputs fetch_cnt[31:0] (count of accepted transfers) and stall_cnt[31:0] (cycles in VALID with ins_ready=0)
- both reset to 0, wrap at 2^32, unaffected by redirect
Undefined: these ports and their counter logic are absent.

Decomposition:
- Package ins_fetch_pkg: state enum {FETCH, VALID, HALT}, INSN_BYTES=4, BYTE_W=8, default RESET_PC.
- Sub-module fetch_byte_shifter: 8-bit-in/32-bit-out big-endian assembler with load-enable and clear; the FSM drives its enable and clear.

Test Plan:
- Reset, memory bytes 0..3 = 8C,22,00,04, ins_ready=1 -> ins_valid at cycle 5, ins=32'h8C220004, ins_pc=0; next ins_pc=4 six cycles later.
- Hold ins_ready=0 for 10 cycles in VALID -> ins/ins_pc stable, mem_rd=0; with FETCH_STATS_EN, stall_cnt=10.
- Redirect to 32'h20 at k=2 -> next mem_addr sequence 20,21,22,23, ins_pc=32'h20, old partial bytes absent.
- Redirect to 32'h22 -> align_err=1, no mem_rd; then redirect to 32'h40 -> align_err=0, fetch resumes at 40.
- Redirect plus ins_ready in same VALID cycle, redirect_pc=32'h80 -> transfer counted (fetch_cnt+1), next ins_pc=32'h80.
- pc=32'hFC, ADDR_W=8 -> mem_addr FC,FD,FE,FF; next pc=32'h100 gives mem_addr 00; rst_n low mid-fetch -> ins_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// ins_fetch_pkg: shared types and constants for the instruction fetch sequencer.
package ins_fetch_pkg;
  typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;
  localparam int INSN_BYTES = 4;
  localparam int BYTE_W = 8;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_byte_shifter.sv
// fetch_byte_shifter: big-endian byte assembler, first byte in lands in the top byte.
module fetch_byte_shifter
  import ins_fetch_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           clr,
  input  logic [BYTE_W-1:0]              din,
  output logic [INSN_BYTES*BYTE_W-1:0]   dout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout <= '0;
    else if (clr) dout <= '0;
    else if (en) dout <= {dout[(INSN_BYTES-1)*BYTE_W-1:0], din};
endmodule

// File: rtl/ins_fetch_seq.sv
// ins_fetch_seq: byte-serial instruction fetch with valid/ready output and PC redirect.
// Optional FETCH_STATS_EN adds fetch_cnt/stall_cnt counters.
module ins_fetch_seq
  import ins_fetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [31:0]       ins,
  output logic [31:0]       ins_pc,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              align_err
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  state_t state, nstate;
  logic [2:0] k, nk;
  logic [31:0] pc;
  logic [ADDR_W-1:0] last_addr;
  logic capture, misaligned, accept, last_byte;
  assign misaligned = redirect && redirect_pc[1:0] != 2'b00;
  assign accept = state == VALID && ins_ready;
  assign last_byte = state == FETCH && k == 3'(INSN_BYTES);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      k <= '0;
    end else begin
      state <= nstate;
      k <= nk;
    end
  always_comb begin
    nstate = redirect ? (misaligned ? HALT : FETCH) :
             state == FETCH ? (last_byte ? VALID : FETCH) :
             accept ? FETCH : state;
    nk = (!redirect && state == FETCH && !last_byte) ? k + 3'd1 : 3'd0;
  end
  // Reset gates the strobe so memory sees no read while held in reset.
  always_comb begin
    mem_rd = rst_n && state == FETCH && !last_byte;
    mem_addr = mem_rd ? pc[ADDR_W-1:0] + ADDR_W'(k) : last_addr;
    ins_valid = state == VALID;
    capture = state == FETCH && k != 3'd0 && !redirect;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      ins_pc <= '0;
      last_addr <= '0;
      align_err <= 1'b0;
    end else begin
      if (redirect) begin
        align_err <= misaligned;
        if (!misaligned) pc <= redirect_pc;
      end else if (accept) pc <= pc + 32'(INSN_BYTES);
      if (last_byte && !redirect) ins_pc <= pc;
      if (mem_rd) last_addr <= mem_addr;
    end
  fetch_byte_shifter u_shift (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (capture),
    .clr  (redirect),
    .din  (mem_rdata),
    .dout (ins)
  );
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) fetch_cnt <= fetch_cnt + 32'd1;
      if (state == VALID && !ins_ready) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
